// File: rtl/mc_if.sv
// mc_if: control bundle between the multi-cycle sequencer and the MIPS datapath
interface mc_if;
  logic [31:0] instr;
  logic        zero;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic [1:0]  a3_sel;
  logic [1:0]  wd_sel;
  logic        mem_write;
  logic        alu_src_b;
  logic        ext_op;
  logic [2:0]  alu_op;
  logic [2:0]  state;
  logic        instr_done;
  logic [31:0] retired;
  modport master (
    input  instr, zero,
    output ir_write, pc_write, pc_src, reg_write, a3_sel, wd_sel, mem_write,
           alu_src_b, ext_op, alu_op, state, instr_done, retired
  );
  modport slave (
    output instr, zero,
    input  ir_write, pc_write, pc_src, reg_write, a3_sel, wd_sel, mem_write,
           alu_src_b, ext_op, alu_op, state, instr_done, retired
  );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: FETCH/DECODE/EXEC/MEM/WB sequencer driving the multi-cycle MIPS datapath
module mc_controller (
  input logic clk,
  input logic reset,
  mc_if.master bus
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  state_t st, nxt;
  logic [31:0] retired;
  logic [5:0] op, fn;
  logic addu, subu, jr, ori, lui, lw, sw, beq, j, jal, unk, jmp;
  logic f, d, e, m, w, done;
  logic unused_bits;
  assign op   = bus.instr[31:26];
  assign fn   = bus.instr[5:0];
  assign addu = op == 6'b000000 && fn == 6'b100001;
  assign subu = op == 6'b000000 && fn == 6'b100011;
  assign jr   = op == 6'b000000 && fn == 6'b001000;
  assign ori  = op == 6'b001101;
  assign lui  = op == 6'b001111;
  assign lw   = op == 6'b100011;
  assign sw   = op == 6'b101011;
  assign beq  = op == 6'b000100;
  assign j    = op == 6'b000010;
  assign jal  = op == 6'b000011;
  assign unk  = !(addu | subu | jr | ori | lui | lw | sw | beq | j | jal);
  assign jmp  = j | jal | jr | unk;
  assign unused_bits = ^bus.instr[25:6];
  // state decodes are gated by reset so no enable is visible while held in reset
  assign f = reset && st == FETCH;
  assign d = reset && st == DECODE;
  assign e = reset && st == EXEC;
  assign m = reset && st == MEM;
  assign w = reset && st == WB;
  assign done = (d & jmp) | (e & beq) | (m & sw) | w;
  always_comb begin
    nxt = st == FETCH  ? DECODE :
          st == DECODE ? (jmp ? FETCH : EXEC) :
          st == EXEC   ? (beq ? FETCH : (lw | sw) ? MEM : WB) :
          st == MEM    ? (sw ? FETCH : WB) : FETCH;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= FETCH;
      retired <= '0;
    end else begin
      st      <= nxt;
      retired <= retired + {31'd0, done};
    end
  end
  assign bus.ir_write   = f;
  assign bus.pc_write   = f | (d & (j | jal | jr)) | (e & beq & bus.zero);
  assign bus.pc_src     = d & (j | jal) ? 2'b10 : d & jr ? 2'b11 : e & beq ? 2'b01 : 2'b00;
  assign bus.reg_write  = (d & jal) | (w & (addu | subu | ori | lui | lw));
  assign bus.a3_sel     = d & jal ? 2'b10 : w & (ori | lui | lw) ? 2'b01 : 2'b00;
  assign bus.wd_sel     = d & jal ? 2'b10 : w & lw ? 2'b01 : 2'b00;
  assign bus.mem_write  = m & sw;
  assign bus.alu_src_b  = e & (ori | lui | lw | sw);
  assign bus.ext_op     = e & (lw | sw);
  assign bus.alu_op     = e & (subu | beq) ? 3'b001 : e & ori ? 3'b010 : e & lui ? 3'b011 : 3'b000;
  assign bus.state      = st;
  assign bus.instr_done = done;
  assign bus.retired    = retired;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed vectors with hand-computed expectations for mc_controller
module tb_mc_controller;
  logic clk = 0;
  logic reset = 0;
  int vectors = 0;
  int miscompares = 0;
  mc_if bus ();
  mc_controller dut (.clk(clk), .reset(reset), .bus(bus.master));
  always #5 clk = ~clk;
  localparam logic [31:0] ADDU = 32'h00851021, LW = 32'h8C820004, SW = 32'hAC820008,
    BEQ = 32'h10850003, JAL = 32'h0C000C00, JR = 32'h03E00008, ORI = 32'h34850001,
    LUI = 32'h3C050001, UNK = 32'hFC000000;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.instr = 32'h0;
    bus.zero = 1'b0;
    repeat (3) step();
    chk("rst_state", bus.state, 0);
    chk("rst_ir_write", bus.ir_write, 0);
    chk("rst_pc_write", bus.pc_write, 0);
    chk("rst_done", bus.instr_done, 0);
    chk("rst_retired", bus.retired, 0);
    reset = 1;
    bus.instr = ADDU;
    #1;
    chk("fetch_ir_write", bus.ir_write, 1);
    chk("fetch_pc_write", bus.pc_write, 1);
    chk("fetch_pc_src", bus.pc_src, 0);
    step(); chk("addu_d", bus.state, 1);
    chk("addu_d_done", bus.instr_done, 0);
    step(); chk("addu_e", bus.state, 2);
    chk("addu_e_alu", {bus.alu_src_b, bus.alu_op}, 4'b0000);
    step(); chk("addu_w", bus.state, 4);
    chk("addu_w_ctl", {bus.reg_write, bus.a3_sel, bus.wd_sel, bus.instr_done}, 6'b100001);
    step(); chk("addu_ret", bus.retired, 1);
    chk("addu_back", bus.state, 0);
    bus.instr = LW;
    step(); step();
    chk("lw_e", {bus.alu_src_b, bus.ext_op, bus.alu_op}, 5'b11000);
    step(); chk("lw_m", bus.state, 3);
    chk("lw_m_en", {bus.mem_write, bus.reg_write, bus.instr_done}, 3'b000);
    step(); chk("lw_w", {bus.state, bus.reg_write, bus.a3_sel, bus.wd_sel}, 8'b100_1_01_01);
    step(); bus.instr = SW;
    chk("lw_ret", bus.retired, 2);
    step(); step();
    chk("sw_e_mw", bus.mem_write, 0);
    step(); chk("sw_m", {bus.state, bus.mem_write, bus.instr_done, bus.reg_write}, 6'b011_110);
    step(); chk("sw_f", {bus.state, bus.mem_write}, 4'b0000);
    chk("sw_ret", bus.retired, 3);
    bus.instr = BEQ;
    step(); bus.zero = 1; #1;
    chk("beq_d_pcw", bus.pc_write, 0);
    step(); chk("beq_taken", {bus.state, bus.pc_write, bus.pc_src, bus.alu_op, bus.instr_done}, 10'b010_1_01_001_1);
    bus.zero = 0; #1;
    chk("beq_zero_drop", bus.pc_write, 0);
    step(); chk("beq_ret", {bus.state, bus.retired[3:0]}, 7'b000_0100);
    step(); step();
    chk("beq_not_taken", {bus.state, bus.pc_write, bus.pc_src}, 6'b010_0_01);
    step(); chk("beq2_ret", bus.retired, 5);
    bus.instr = JAL;
    step(); chk("jal_d", {bus.state, bus.pc_write, bus.pc_src, bus.reg_write, bus.a3_sel, bus.wd_sel, bus.instr_done},
                12'b001_1_10_1_10_10_1);
    step(); chk("jal_f", {bus.state, bus.ir_write}, 4'b0001);
    chk("jal_ret", bus.retired, 6);
    bus.instr = JR;
    step(); chk("jr_d", {bus.pc_write, bus.pc_src, bus.reg_write}, 4'b1110);
    step(); chk("jr_ret", {bus.state, bus.retired[3:0]}, 7'b000_0111);
    bus.instr = ORI;
    step(); step();
    chk("ori_e", {bus.alu_src_b, bus.ext_op, bus.alu_op}, 5'b10010);
    step(); chk("ori_w", {bus.reg_write, bus.a3_sel, bus.wd_sel}, 5'b10100);
    step(); bus.instr = LUI;
    step(); step();
    chk("lui_e", {bus.alu_src_b, bus.alu_op}, 4'b1011);
    step(); chk("lui_w", {bus.state, bus.reg_write, bus.a3_sel}, 6'b100_1_01);
    step(); chk("lui_ret", bus.retired, 9);
    bus.instr = LW;
    step(); step(); step();
    chk("abort_pre", bus.state, 3);
    #2 reset = 0;
    #1;
    chk("abort_state", bus.state, 0);
    chk("abort_en", {bus.reg_write, bus.ir_write, bus.pc_write, bus.mem_write, bus.instr_done}, 5'b00000);
    chk("abort_retired", bus.retired, 0);
    step();
    chk("abort_hold", {bus.state, bus.reg_write}, 4'b0000);
    reset = 1;
    bus.instr = UNK;
    step(); chk("unk_d", {bus.state, bus.instr_done, bus.pc_write, bus.reg_write, bus.ir_write}, 7'b001_1000);
    step(); chk("unk_f", bus.state, 0);
    chk("unk_ret", bus.retired, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
